// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 4-lane TDM receive demultiplexer.
package tdm_demux_pkg;
  localparam int NLANES      = 4;
  localparam int SLOT_W      = 2;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/tdm_slot_ctrl.sv
// Frame alignment FSM and slot counter: turns valid/sync into one-hot lane
// write enables plus frame completion / abort strobes (combinational, registered by the top).
module tdm_slot_ctrl
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              sync,
  output logic [NLANES-1:0] lane_we,
  output logic              frame_done,
  output logic              frame_err,
  output logic              locked,
  output logic [SLOT_W-1:0] slot
);
  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    lane_we    = '0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (din_valid) begin
      case (state_q)
        IDLE: begin
          // Unaligned samples are dropped until a sync marks slot 0.
          if (sync) begin
            lane_we[0] = 1'b1;
            slot_d     = SLOT_W'(1);
            state_d    = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // Sync always restarts the frame; mid-frame it aborts the partial one.
            lane_we[0] = 1'b1;
            slot_d     = SLOT_W'(1);
            frame_err  = (slot_q != '0);
          end else begin
            lane_we[slot_q] = 1'b1;
            slot_d          = slot_q + SLOT_W'(1);
            frame_done      = (slot_q == SLOT_W'(NLANES - 1));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign locked = (state_q == RUN);
  assign slot   = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// Time-division 1-to-4 demultiplexer: shadow lanes fill per slot, y and the
// frame strobes are registered. Optional frame counter under TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    sync,
  output logic [NLANES*WIDTH-1:0] y,
  output logic                    frame_valid,
  output logic                    frame_err,
`ifdef TDM_DEMUX_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0]  frame_cnt,
`endif
  output logic                    locked,
  output logic [SLOT_W-1:0]       slot
);
  logic [NLANES-1:0]             lane_we;
  logic                          done, err;
  logic [NLANES-1:0][WIDTH-1:0]  lanes_q, lanes_d;
  logic [NLANES-1:0][WIDTH-1:0]  y_q, y_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          frame_err_q, frame_err_d;

  tdm_slot_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .sync       (sync),
    .lane_we    (lane_we),
    .frame_done (done),
    .frame_err  (err),
    .locked     (locked),
    .slot       (slot)
  );

  always_comb begin
    lanes_d = lanes_q;
    for (int i = 0; i < NLANES; i++)
      if (lane_we[i]) lanes_d[i] = din;
    // lanes_d already carries the lane3 sample on the completing cycle.
    y_d           = done ? lanes_d : y_q;
    frame_valid_d = done;
    frame_err_d   = err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q       <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      lanes_q       <= lanes_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign y           = y_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + (done ? FRAME_CNT_W'(1) : FRAME_CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=1): stimulus pushes expected strobes,
// a negedge monitor pops and compares them.
module tb_tdm_demux4;
  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       sync;
  logic [3:0] y;
  logic       frame_valid;
  logic       frame_err;
  logic       locked;
  logic [1:0] slot;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       is_err;
    logic [3:0] y;
  } exp_t;
  exp_t exp_q[$];

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y           (y),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
`ifdef TDM_DEMUX_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .locked      (locked),
    .slot        (slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      exp_t e;
      chk("strobe_exclusive", int'(frame_valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got fv=%0b fe=%0b y=%b expected none",
                 frame_valid, frame_err, y);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", int'(frame_err), int'(e.is_err));
        chk("strobe_y", int'(y), int'(e.y));
      end
    end
  end

  task automatic send(input logic d, input logic s);
    @(negedge clk);
    din = d; sync = s; din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0; sync = 1'b0; din = 1'b0;
    end
  endtask

  task automatic push(input logic is_err, input logic [3:0] v);
    exp_t e;
    e.is_err = is_err;
    e.y      = v;
    exp_q.push_back(e);
  endtask

  // d[0] is lane0 (slot 0) ... d[3] is lane3; y equals d after completion.
  task automatic send_frame(input logic [3:0] d);
    send(d[0], 1'b1);
    send(d[1], 1'b0);
    send(d[2], 1'b0);
    push(1'b0, d);
    send(d[3], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y", int'(y), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_fe", int'(frame_err), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_slot", int'(slot), 0);
    rst = 1'b0;

    // Unsynced samples in IDLE are dropped.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    idle(2);
    chk("idle_locked", int'(locked), 0);
    chk("idle_slot", int'(slot), 0);
    chk("idle_y", int'(y), 0);

    // Frame 1,0,1,1 -> y=1101.
    send_frame(4'b1101);
    idle(1);
    chk("f1_locked", int'(locked), 1);
    chk("f1_slot", int'(slot), 0);
    chk("f1_y", int'(y), 4'b1101);
    idle(1);
    chk("f1_fv_one_cycle", int'(frame_valid), 0);

    // Frame 0,1,1,0 with a 3-cycle gap between samples 2 and 3.
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    idle(3);
    chk("gap_no_fv", int'(frame_valid), 0);
    chk("gap_slot", int'(slot), 2);
    send(1'b1, 1'b0);
    push(1'b0, 4'b0110);
    send(1'b0, 1'b0);
    idle(2);
    chk("f2_y", int'(y), 4'b0110);

    // Mid-frame sync aborts: lane0=1 restarts, then 0,0,1 -> y=1001.
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    push(1'b1, 4'b0110);
    send(1'b1, 1'b1);
    idle(1);
    chk("err_slot", int'(slot), 1);
    chk("err_y_hold", int'(y), 4'b0110);
    chk("err_locked", int'(locked), 1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    push(1'b0, 4'b1001);
    send(1'b1, 1'b0);
    idle(2);
    chk("f3_y", int'(y), 4'b1001);

    // Reset mid-frame at slot 2, then a clean frame.
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    idle(1);
    chk("pre_rst_slot", int'(slot), 2);
    do_reset();
    chk("mrst_y", int'(y), 0);
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_slot", int'(slot), 0);
    send_frame(4'b1010);
    idle(2);
    chk("f4_y", int'(y), 4'b1010);
    chk("f4_locked", int'(locked), 1);

`ifdef TDM_DEMUX_FRAME_CNT_EN
    do_reset();
    chk("cnt_rst", int'(frame_cnt), 0);
    // Aborted frame must not count.
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    push(1'b1, 4'b0000);
    send(1'b0, 1'b1);
    idle(1);
    chk("cnt_after_err", int'(frame_cnt), 0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    push(1'b0, 4'b0000);
    send(1'b0, 1'b0);
    idle(1);
    chk("cnt_first", int'(frame_cnt), 1);
    for (int k = 1; k < 257; k++) begin
      logic [3:0] v;
      v = 4'(k);
      send_frame(v);
    end
    idle(2);
    chk("cnt_wrap", int'(frame_cnt), 1);
    chk("cnt_last_y", int'(y), 4'(256));
`endif

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the run ever overruns its budget.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
